// File: rtl/p18_pkg.sv
// ---------------------------------------------------------------------------
// p18_pkg
// Shared definitions for the sprite-position serial load transmitter.
//   tx_state_t   : transmitter FSM states
//   COORD_WIDTH  : width of one sprite coordinate
//   phase_width  : width of the per-bit phase counter for a given bit period
// ---------------------------------------------------------------------------
package p18_pkg;

    localparam int COORD_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_FRAME,
        SHIFT
    } tx_state_t;

    // A bit period of 1 still needs a one-bit counter so the logic stays
    // uniform; it simply never leaves zero.
    function automatic int phase_width(input int period);
        return (period > 1) ? $clog2(period) : 1;
    endfunction

endpackage

// File: rtl/p18_serial_lane.sv
// ---------------------------------------------------------------------------
// p18_serial_lane
// One serial channel (X or Y) of the sprite-position transmitter: an 8-bit
// shift register sent MSB-first with a gated shift strobe.
//   clk, reset  : clock, asynchronous active-high reset
//   load        : capture load_value into the shift register
//   load_value  : coordinate to send
//   advance     : shift the register left by one (end of a bit period)
//   en          : channel enable that applies to the coming cycle
//   emit        : the coming cycle belongs to the SHIFT phase of a transfer
//   strobe      : the coming cycle is the first phase of a bit
//   shift       : registered shift strobe to the movement block
//   data        : registered serial data (MSB of the shift register)
// ---------------------------------------------------------------------------
module p18_serial_lane
    import p18_pkg::*;
(
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [COORD_WIDTH-1:0] load_value,
    input  logic                   advance,
    input  logic                   en,
    input  logic                   emit,
    input  logic                   strobe,
    output logic                   shift,
    output logic                   data
);

    logic [COORD_WIDTH-1:0] sreg;
    logic [COORD_WIDTH-1:0] sreg_next;

    always_comb begin
        sreg_next = sreg;
        if (load) begin
            sreg_next = load_value;
        end else if (advance) begin
            sreg_next = {sreg[COORD_WIDTH-2:0], 1'b0};
        end
    end

    // The outputs are computed from next-cycle values so that they are
    // flops yet line up with the cycle the FSM is actually in.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sreg  <= '0;
            shift <= 1'b0;
            data  <= 1'b0;
        end else begin
            sreg  <= sreg_next;
            shift <= emit & en & strobe;
            data  <= emit & en & sreg_next[COORD_WIDTH-1];
        end
    end

endmodule

// File: rtl/p18_sprite_position_tx.sv
// ---------------------------------------------------------------------------
// p18_sprite_position_tx
// Transmitter for the sprite-position serial load channel. Takes an X/Y
// coordinate pair over valid/ready and serializes it MSB-first onto the
// shift/data line pairs of the sprite movement block, optionally waiting for
// the frame tick so a movement step never lands inside a load.
//   Parameters: BIT_PERIOD (cycles per bit, >=1),
//               SYNC_TO_FRAME (1 = first bit waits for next_frame)
//   clk, reset          : clock, asynchronous active-high reset
//   next_frame          : one-cycle frame-completed pulse
//   req_valid/req_ready : request handshake (ready only in IDLE)
//   req_x, req_y        : coordinates to load
//   req_en_x, req_en_y  : per-channel send enables
//   shift_x, data_x     : X channel strobe and serial data
//   shift_y, data_y     : Y channel strobe and serial data
//   busy                : high outside IDLE
//   done                : one-cycle pulse on return to IDLE
// ---------------------------------------------------------------------------
module p18_sprite_position_tx
    import p18_pkg::*;
#(
    parameter int BIT_PERIOD    = 1,
    parameter bit SYNC_TO_FRAME = 1'b1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   next_frame,
    input  logic                   req_valid,
    output logic                   req_ready,
    input  logic [COORD_WIDTH-1:0] req_x,
    input  logic [COORD_WIDTH-1:0] req_y,
    input  logic                   req_en_x,
    input  logic                   req_en_y,
    output logic                   shift_x,
    output logic                   data_x,
    output logic                   shift_y,
    output logic                   data_y,
    output logic                   busy,
    output logic                   done
);

    localparam int              PW         = phase_width(BIT_PERIOD);
    localparam logic [PW-1:0]   LAST_PHASE = PW'(BIT_PERIOD - 1);

    tx_state_t     state;
    logic [PW-1:0] phase;
    logic [2:0]    bit_cnt;
    logic          en_x;
    logic          en_y;

    logic          accept;
    logic          load;
    logic          advance;
    logic          last_bit;
    logic          emit;
    logic          strobe;
    logic          lane_en_x;
    logic          lane_en_y;

    assign req_ready = (state == IDLE);
    assign busy      = (state != IDLE);

    // Control decode shared by the FSM and both lanes. 'emit' and 'strobe'
    // describe the next cycle so the lanes can register their outputs.
    always_comb begin
        accept    = (state == IDLE) && req_valid;
        load      = accept;
        advance   = (state == SHIFT) && (phase == LAST_PHASE);
        last_bit  = advance && (bit_cnt == 3'd7);
        emit      = ((state == SHIFT) && !last_bit) ||
                    (accept && !SYNC_TO_FRAME) ||
                    ((state == WAIT_FRAME) && next_frame);
        strobe    = (state != SHIFT) || (phase == LAST_PHASE);
        lane_en_x = load ? req_en_x : en_x;
        lane_en_y = load ? req_en_y : en_y;
    end

    // Transfer FSM with the shared phase/bit counters. next_frame only
    // matters in WAIT_FRAME, so a pulse in the accept cycle or mid-shift is
    // ignored naturally.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            phase   <= '0;
            bit_cnt <= '0;
            en_x    <= 1'b0;
            en_y    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        en_x    <= req_en_x;
                        en_y    <= req_en_y;
                        phase   <= '0;
                        bit_cnt <= '0;
                        state   <= SYNC_TO_FRAME ? WAIT_FRAME : SHIFT;
                    end
                end
                WAIT_FRAME: begin
                    if (next_frame) begin
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (phase == LAST_PHASE) begin
                        phase <= '0;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            state   <= IDLE;
                            done    <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end else begin
                        phase <= phase + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    p18_serial_lane u_lane_x (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (req_x),
        .advance    (advance),
        .en         (lane_en_x),
        .emit       (emit),
        .strobe     (strobe),
        .shift      (shift_x),
        .data       (data_x)
    );

    p18_serial_lane u_lane_y (
        .clk        (clk),
        .reset      (reset),
        .load       (load),
        .load_value (req_y),
        .advance    (advance),
        .en         (lane_en_y),
        .emit       (emit),
        .strobe     (strobe),
        .shift      (shift_y),
        .data       (data_y)
    );

endmodule
